// File: rtl/flop_stim_gen_if.sv
// Controller-side and flop-pin signals of the flip-flop stimulus generator.
// The controller side uses the master modport and the generator uses the slave modport.
interface flop_stim_gen_if #(
    parameter int CNT_W  = 8,
    parameter int NCYC_W = 8,
    parameter int DATA_W = 16
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  clr_ticks;
    logic [CNT_W-1:0]  lo_ticks;
    logic [CNT_W-1:0]  hi_ticks;
    logic [CNT_W-1:0]  setup_ticks;
    logic [NCYC_W-1:0] ncycles;
    logic [DATA_W-1:0] data_in;
    logic              dut_clk;
    logic              dut_d;
    logic              dut_clr_n;
    logic              dut_set_n;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, clr_ticks, lo_ticks, hi_ticks, setup_ticks, ncycles, data_in,
        input  dut_clk, dut_d, dut_clr_n, dut_set_n, busy, done
    );

    modport slave (
        input  start, abort, clr_ticks, lo_ticks, hi_ticks, setup_ticks, ncycles, data_in,
        output dut_clk, dut_d, dut_clr_n, dut_set_n, busy, done
    );
endinterface

// File: rtl/flop_stim_gen.sv
// Registered stimulus for a clear/set D flip-flop under test: clear pulse, then ncycles
// clock periods with programmable low/high widths and data setup before each rising edge.
module flop_stim_gen #(
    parameter int CNT_W  = 8,
    parameter int NCYC_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    flop_stim_gen_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CLR, LOW, HIGH, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NCYC_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic              d_q, d_d;

    logic [CNT_W-1:0]  clr_sh_q, lo_sh_q, hi_sh_q, su_sh_q;
    logic [NCYC_W-1:0] ncyc_sh_q;

    logic              clk_q, clr_n_q, set_n_q, busy_q, done_q;

    logic              idle;
    logic [CNT_W-1:0]  cfg_clr, cfg_lo, cfg_hi, cfg_su;
    logic [NCYC_W-1:0] cfg_ncyc;
    logic [CNT_W-1:0]  len_lo, len_hi, len_su;

    assign idle = (state_q == IDLE);

    // In IDLE the decision for the first transition is taken from the live inputs,
    // since the shadow copies are only written on that same edge.
    always_comb begin
        cfg_clr  = idle ? bus.clr_ticks   : clr_sh_q;
        cfg_lo   = idle ? bus.lo_ticks    : lo_sh_q;
        cfg_hi   = idle ? bus.hi_ticks    : hi_sh_q;
        cfg_su   = idle ? bus.setup_ticks : su_sh_q;
        cfg_ncyc = idle ? bus.ncycles     : ncyc_sh_q;
        len_lo   = (cfg_lo == '0) ? CNT_W'(1) : cfg_lo;
        len_hi   = (cfg_hi == '0) ? CNT_W'(1) : cfg_hi;
        len_su   = (cfg_su == '0) ? CNT_W'(1) : cfg_su;
        if (len_su > len_lo)
            len_su = len_lo;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        pat_d   = pat_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d  = bus.data_in;
                    edge_d = '0;
                    if (cfg_clr != '0) begin
                        state_d = CLR;
                        cnt_d   = cfg_clr - CNT_W'(1);
                    end else if (cfg_ncyc != '0) begin
                        state_d = LOW;
                        cnt_d   = len_lo - CNT_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLR: begin
                if (cnt_q == '0) begin
                    if (cfg_ncyc != '0) begin
                        state_d = LOW;
                        cnt_d   = len_lo - CNT_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = len_hi - CNT_W'(1);
                    edge_d  = edge_q + NCYC_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    if (edge_q == cfg_ncyc) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOW;
                        cnt_d   = len_lo - CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!idle && bus.abort)
            state_d = IDLE;

        // The next pattern bit appears exactly len_su cycles before the rise.
        if (state_d == LOW && cnt_d == len_su - CNT_W'(1)) begin
            d_d   = pat_d[0];
            pat_d = pat_d >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            d_q     <= 1'b0;
            clk_q   <= 1'b0;
            clr_n_q <= 1'b0;
            set_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            d_q     <= d_d;
            clk_q   <= (state_d == HIGH);
            clr_n_q <= (state_d != CLR);
            set_n_q <= 1'b1;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        pat_q <= pat_d;
        if (idle && bus.start) begin
            clr_sh_q  <= bus.clr_ticks;
            lo_sh_q   <= bus.lo_ticks;
            hi_sh_q   <= bus.hi_ticks;
            su_sh_q   <= bus.setup_ticks;
            ncyc_sh_q <= bus.ncycles;
        end
    end

    assign bus.dut_clk   = clk_q;
    assign bus.dut_d     = d_q;
    assign bus.dut_clr_n = clr_n_q;
    assign bus.dut_set_n = set_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_flop_stim_gen.sv
// Randomized self-checking bench for flop_stim_gen against a per-cycle waveform model
// built directly from the clear/low/high/setup timing rules.
module tb_flop_stim_gen;
    localparam int CNT_W  = 8;
    localparam int NCYC_W = 8;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flop_stim_gen_if #(.CNT_W(CNT_W), .NCYC_W(NCYC_W), .DATA_W(DATA_W)) bus ();

    flop_stim_gen #(.CNT_W(CNT_W), .NCYC_W(NCYC_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       d_model = 1'b0;
    logic [5:0] expq[$];

    // Vector layout: {dut_clk, dut_d, dut_clr_n, dut_set_n, busy, done}
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] obs_vec();
        return {bus.dut_clk, bus.dut_d, bus.dut_clr_n, bus.dut_set_n, bus.busy, bus.done};
    endfunction

    // Expected outputs for every cycle from the first busy cycle through DONE.
    function automatic void build(input int c, input int lo, input int hi, input int su,
                                  input int nc, input logic [15:0] data);
        int l, h, s;
        l = (lo == 0) ? 1 : lo;
        h = (hi == 0) ? 1 : hi;
        s = (su == 0) ? 1 : su;
        if (s > l) s = l;
        expq.delete();
        for (int i = 0; i < c; i++)
            expq.push_back({1'b0, d_model, 1'b0, 1'b1, 1'b1, 1'b0});
        for (int k = 0; k < nc; k++) begin
            for (int j = 0; j < l; j++) begin
                if (l - j == s)
                    d_model = (k < DATA_W) ? data[k] : 1'b0;
                expq.push_back({1'b0, d_model, 1'b1, 1'b1, 1'b1, 1'b0});
            end
            for (int j = 0; j < h; j++)
                expq.push_back({1'b1, d_model, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        expq.push_back({1'b0, d_model, 1'b1, 1'b1, 1'b1, 1'b1});
    endfunction

    task automatic scramble();
        bus.clr_ticks   = 8'($urandom);
        bus.lo_ticks    = 8'($urandom);
        bus.hi_ticks    = 8'($urandom);
        bus.setup_ticks = 8'($urandom);
        bus.ncycles     = 8'($urandom);
        bus.data_in     = 16'($urandom);
    endtask

    task automatic run_seq(input string name, input int c, input int lo, input int hi,
                           input int su, input int nc, input logic [15:0] data,
                           input int abort_at, input bit junk);
        int n, js, busy_cnt, done_cnt, l, h;
        l = (lo == 0) ? 1 : lo;
        h = (hi == 0) ? 1 : hi;
        build(c, lo, hi, su, nc, data);
        n = expq.size();
        js = junk ? int'($urandom_range(0, n - 1)) : -1;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.clr_ticks   = 8'(c);
        bus.lo_ticks    = 8'(lo);
        bus.hi_ticks    = 8'(hi);
        bus.setup_ticks = 8'(su);
        bus.ncycles     = 8'(nc);
        bus.data_in     = data;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_c%0d", name, i), 32'(obs_vec()), 32'(expq[i]));
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            if (junk) scramble();
            bus.start = (i == js);
            if (i == abort_at) begin
                bus.start = 1'b0;
                bus.abort = 1'b1;
                d_model   = expq[i][4];
                @(negedge clk);
                bus.abort = 1'b0;
                chk($sformatf("%s_abort", name), 32'(obs_vec()),
                    32'({1'b0, d_model, 1'b1, 1'b1, 1'b0, 1'b0}));
                @(negedge clk);
                chk($sformatf("%s_abort_idle", name), 32'(obs_vec()),
                    32'({1'b0, d_model, 1'b1, 1'b1, 1'b0, 1'b0}));
                return;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk($sformatf("%s_idle", name), 32'(obs_vec()),
            32'({1'b0, d_model, 1'b1, 1'b1, 1'b0, 1'b0}));
        chk($sformatf("%s_busylen", name), 32'(busy_cnt), 32'(c + nc * (l + h) + 1));
        chk($sformatf("%s_donecnt", name), 32'(done_cnt), 32'd1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.clr_ticks = '0; bus.lo_ticks = '0; bus.hi_ticks = '0;
        bus.setup_ticks = '0; bus.ncycles = '0; bus.data_in = '0;

        // Reset values and clear release one edge after rst falls
        @(negedge clk);
        chk("rst_vals", 32'(obs_vec()), 32'(6'b000100));
        rst = 1'b0;
        #1;
        chk("rst_rel_pre", 32'(bus.dut_clr_n), 32'd0);
        @(negedge clk);
        chk("rst_rel_post", 32'(obs_vec()), 32'(6'b001100));

        run_seq("t2", 3, 4, 2, 2, 3, 16'b101, -1, 1'b0);
        run_seq("t3", 0, 3, 3, 1, 0, 16'hFFFF, -1, 1'b0);
        run_seq("t4", 0, 0, 0, 9, 4, 16'b0101, -1, 1'b0);
        run_seq("t5_junk", 3, 4, 2, 2, 3, 16'b101, -1, 1'b1);
        run_seq("t5_abort", 3, 4, 2, 2, 3, 16'b101, 7, 1'b0);

        // Asynchronous reset between edges in the middle of a LOW phase
        @(negedge clk);
        bus.start = 1'b1;
        bus.clr_ticks = 8'd3; bus.lo_ticks = 8'd4; bus.hi_ticks = 8'd2;
        bus.setup_ticks = 8'd2; bus.ncycles = 8'd3; bus.data_in = 16'b101;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("t6_async", 32'(obs_vec()), 32'(6'b000100));
        @(negedge clk);
        chk("t6_held", 32'(obs_vec()), 32'(6'b000100));
        rst = 1'b0;
        d_model = 1'b0;
        @(negedge clk);
        chk("t6_rel", 32'(obs_vec()), 32'(6'b001100));
        run_seq("t6_again", 3, 4, 2, 2, 3, 16'b101, -1, 1'b0);

        for (int t = 0; t < 14; t++) begin
            int c, lo, hi, su, nc, ab, len;
            c  = $urandom_range(0, 4);
            lo = $urandom_range(0, 5);
            hi = $urandom_range(0, 4);
            su = $urandom_range(0, 7);
            nc = (t == 13) ? 20 : int'($urandom_range(0, 8));
            len = c + nc * (((lo == 0) ? 1 : lo) + ((hi == 0) ? 1 : hi)) + 1;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_seq($sformatf("rnd%0d", t), c, lo, hi, su, nc, 16'($urandom), ab, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
